// File: rtl/input_holder.sv
// input_holder: synchronized 4-phase pin write port feeding a DEPTH-entry FIFO that issues ready-gated pulses to the cipher core.
// Build option INPUT_HOLDER_LEVEL_EN adds the fifo_level occupancy output.

module input_holder_checker #(
  parameter int DEPTH = 4
) (
  input logic                    clk,
  input logic                    nrst,
  input logic                    fifo_empty,
  input logic                    fifo_full,
  input logic                    core_ready,
  input logic                    data_out_pulse,
  input logic [$clog2(DEPTH):0]  count
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  a_flags_exclusive: assert property (@(posedge clk) disable iff (!nrst)
    !(fifo_empty && fifo_full));

  a_count_range: assert property (@(posedge clk) disable iff (!nrst)
    count <= FULL_CNT);

  a_pulse_needs_ready: assert property (@(posedge clk) disable iff (!nrst)
    data_out_pulse |-> $past(core_ready));
endmodule

module input_holder #(
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic [7:0]             pin_data,
  input  logic                   pin_wr_req,
  output logic                   pin_wr_ack,
  input  logic                   core_ready,
  output logic [7:0]             data_out,
  output logic                   data_out_pulse,
  input  logic                   flush,
  output logic                   fifo_empty,
`ifdef INPUT_HOLDER_LEVEL_EN
  output logic                   fifo_full,
  output logic [$clog2(DEPTH):0] fifo_level
`else
  output logic                   fifo_full
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] ZERO_CNT = {CW{1'b0}};

  typedef enum logic [0:0] {
    WAIT_REQ     = 1'b0,
    WAIT_RELEASE = 1'b1
  } state_t;

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   req_s;

  state_t                 state_r;
  state_t                 state_next_s;
  logic                   ack_r;
  logic                   ack_next_s;
  logic                   push_s;
  logic                   pop_s;
  logic                   full_now_s;

  logic [7:0]             mem_r [DEPTH];
  logic [AW-1:0]          wr_ptr_r;
  logic [AW-1:0]          rd_ptr_r;
  logic [CW-1:0]          count_r;
  logic [CW-1:0]          count_next_s;

  logic [7:0]             data_out_r;
  logic                   pulse_r;
  logic                   empty_r;
  logic                   full_r;

  // Shift the asynchronous request level through the synchronizer chain.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      sync_r <= {SYNC_STAGES{1'b0}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], pin_wr_req};
    end
  end

  assign req_s = sync_r[SYNC_STAGES-1];

  // Full/empty decisions look at the count before this cycle's update.
  assign full_now_s = (count_r == FULL_CNT);
  assign pop_s      = core_ready && (count_r != ZERO_CNT) && !flush;

  // Handshake state and acknowledge registers.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_r <= WAIT_REQ;
      ack_r   <= 1'b0;
    end else begin
      state_r <= state_next_s;
      ack_r   <= ack_next_s;
    end
  end

  // Handshake next state: one push per request high phase, held off while full or flushing.
  always_comb begin
    state_next_s = state_r;
    ack_next_s   = ack_r;
    push_s       = 1'b0;
    case (state_r)
      WAIT_REQ: begin
        if (req_s && !flush && !full_now_s) begin
          push_s       = 1'b1;
          ack_next_s   = 1'b1;
          state_next_s = WAIT_RELEASE;
        end else begin
          ack_next_s   = 1'b0;
          state_next_s = WAIT_REQ;
        end
      end
      WAIT_RELEASE: begin
        if (!req_s) begin
          ack_next_s   = 1'b0;
          state_next_s = WAIT_REQ;
        end else begin
          ack_next_s   = 1'b1;
          state_next_s = WAIT_RELEASE;
        end
      end
      default: begin
        ack_next_s   = 1'b0;
        state_next_s = WAIT_REQ;
      end
    endcase
  end

  // Occupancy after this cycle; flush wins over any push or pop.
  always_comb begin
    count_next_s = count_r;
    if (flush) begin
      count_next_s = ZERO_CNT;
    end else begin
      case ({push_s, pop_s})
        2'b10:   count_next_s = count_r + 1'b1;
        2'b01:   count_next_s = count_r - 1'b1;
        default: count_next_s = count_r;
      endcase
    end
  end

  // Storage array; contents need no reset since the count qualifies every read.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= pin_data;
    end
  end

  // Pointers, count and the registered status flags.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= ZERO_CNT;
      empty_r  <= 1'b1;
      full_r   <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr_r <= {AW{1'b0}};
        rd_ptr_r <= {AW{1'b0}};
      end else begin
        if (push_s) begin
          wr_ptr_r <= wr_ptr_r + 1'b1;
        end
        if (pop_s) begin
          rd_ptr_r <= rd_ptr_r + 1'b1;
        end
      end
      count_r <= count_next_s;
      empty_r <= (count_next_s == ZERO_CNT);
      full_r  <= (count_next_s == FULL_CNT);
    end
  end

  // Core-side byte register and one-cycle strobe.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      data_out_r <= 8'h00;
      pulse_r    <= 1'b0;
    end else begin
      pulse_r <= pop_s;
      if (pop_s) begin
        data_out_r <= mem_r[rd_ptr_r];
      end
    end
  end

  assign pin_wr_ack     = ack_r;
  assign data_out       = data_out_r;
  assign data_out_pulse = pulse_r;
  assign fifo_empty     = empty_r;
  assign fifo_full      = full_r;
`ifdef INPUT_HOLDER_LEVEL_EN
  assign fifo_level     = count_r;
`endif

  input_holder_checker #(.DEPTH(DEPTH)) u_checker (
    .clk            (clk),
    .nrst           (nrst),
    .fifo_empty     (empty_r),
    .fifo_full      (full_r),
    .core_ready     (core_ready),
    .data_out_pulse (pulse_r),
    .count          (count_r)
  );
endmodule

// File: tb/tb_input_holder.sv
// Scoreboard bench for input_holder: expected bytes are queued as writes are driven and compared on each data_out_pulse.
module tb_input_holder;
  localparam int DEPTH       = 4;
  localparam int SYNC_STAGES = 2;

  logic       clk = 1'b0;
  logic       nrst;
  logic [7:0] pin_data;
  logic       pin_wr_req;
  logic       pin_wr_ack;
  logic       core_ready;
  logic [7:0] data_out;
  logic       data_out_pulse;
  logic       flush;
  logic       fifo_empty;
  logic       fifo_full;
`ifdef INPUT_HOLDER_LEVEL_EN
  logic [$clog2(DEPTH):0] fifo_level;
`endif

  int         n_checks = 0;
  int         n_pass   = 0;
  int         n_pulses = 0;
  logic [7:0] sb_q[$];
  bit         toggle_en      = 1'b0;
  bit         wrap_full_seen = 1'b0;

  input_holder #(.DEPTH(DEPTH), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk            (clk),
    .nrst           (nrst),
    .pin_data       (pin_data),
    .pin_wr_req     (pin_wr_req),
    .pin_wr_ack     (pin_wr_ack),
    .core_ready     (core_ready),
    .data_out       (data_out),
    .data_out_pulse (data_out_pulse),
    .flush          (flush),
    .fifo_empty     (fifo_empty),
`ifdef INPUT_HOLDER_LEVEL_EN
    .fifo_full      (fifo_full),
    .fifo_level     (fifo_level)
`else
    .fifo_full      (fifo_full)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Output monitor: every pulse must match the oldest expected byte.
  initial begin
    logic [7:0] exp_b;
    forever begin
      @(negedge clk);
      if (data_out_pulse === 1'b1) begin
        n_pulses++;
        check_val("pulse_has_expect", 32'(sb_q.size() > 0), 32'd1);
        if (sb_q.size() > 0) begin
          exp_b = sb_q.pop_front();
          check_val("data_out", {24'd0, data_out}, {24'd0, exp_b});
        end
      end
    end
  end

  // core_ready toggler for the wrap-around phase.
  initial begin
    forever begin
      @(negedge clk);
      if (toggle_en) begin
        core_ready = ~core_ready;
        if (fifo_full) wrap_full_seen = 1'b1;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic wait_ack(input logic lvl, input string tag, output int cyc);
    cyc = 0;
    while (pin_wr_ack !== lvl && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    check_val(tag, {31'd0, pin_wr_ack}, {31'd0, lvl});
  endtask

  task automatic write_byte(input logic [7:0] b);
    int c;
    pin_data   = b;
    pin_wr_req = 1'b1;
    sb_q.push_back(b);
    wait_ack(1'b1, "wr_ack_rise", c);
    pin_wr_req = 1'b0;
    wait_ack(1'b0, "wr_ack_fall", c);
  endtask

  task automatic wait_drain(input string tag);
    int c = 0;
    while (sb_q.size() != 0 && c < 300) begin
      @(negedge clk);
      c++;
    end
    check_val(tag, sb_q.size(), 32'd0);
  endtask

  initial begin
    int  ack_cyc;
    int  pulse_cyc;
    int  c;
    int  npl;
    bit  seen;

    nrst       = 1'b0;
    pin_data   = 8'h00;
    pin_wr_req = 1'b0;
    core_ready = 1'b0;
    flush      = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_val("rst_ack",   pin_wr_ack,     32'd0);
    check_val("rst_pulse", data_out_pulse, 32'd0);
    check_val("rst_data",  data_out,       32'd0);
    check_val("rst_empty", fifo_empty,     32'd1);
    check_val("rst_full",  fifo_full,      32'd0);
    nrst = 1'b1;
    @(negedge clk);

    // Single write: ack after 3 edges, pulse after 4.
    core_ready = 1'b1;
    pin_data   = 8'hA5;
    pin_wr_req = 1'b1;
    sb_q.push_back(8'hA5);
    ack_cyc   = 0;
    pulse_cyc = 0;
    npl       = n_pulses;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (pin_wr_ack === 1'b1 && ack_cyc == 0) ack_cyc = i;
      if (data_out_pulse === 1'b1 && pulse_cyc == 0) pulse_cyc = i;
    end
    check_val("t1_ack_latency",   ack_cyc,        32'd3);
    check_val("t1_pulse_latency", pulse_cyc,      32'd4);
    check_val("t1_pulse_count",   n_pulses - npl, 32'd1);
    check_val("t1_data_hold",     data_out,       32'hA5);
    check_val("t1_empty",         fifo_empty,     32'd1);
    pin_wr_req = 1'b0;
    wait_ack(1'b0, "t1_ack_fall", c);
    check_val("t1_fall_latency", c, 32'd3);

    // Fill to full, then back-pressure on the 5th write.
    core_ready = 1'b0;
    for (int b = 1; b <= 4; b++) write_byte(8'(b));
    check_val("fill_full",  fifo_full,  32'd1);
    check_val("fill_empty", fifo_empty, 32'd0);
    pin_data   = 8'h05;
    pin_wr_req = 1'b1;
    sb_q.push_back(8'h05);
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (pin_wr_ack === 1'b1) seen = 1'b1;
    end
    check_val("full_no_ack", seen, 32'd0);
    core_ready = 1'b1;
    @(negedge clk);
    core_ready = 1'b0;
    wait_ack(1'b1, "full_late_ack", c);
    pin_wr_req = 1'b0;
    wait_ack(1'b0, "full_late_fall", c);
    check_val("refill_full", fifo_full, 32'd1);
    check_val("fill_queue",  sb_q.size(), 32'd4);
    core_ready = 1'b1;
    wait_drain("fill_drain");
    @(negedge clk);
    check_val("fill_empty_end", fifo_empty, 32'd1);

    // Wrap-around with core_ready toggling every cycle.
    core_ready = 1'b0;
    toggle_en  = 1'b1;
    for (int b = 8'h10; b <= 8'h19; b++) write_byte(8'(b));
    toggle_en  = 1'b0;
    core_ready = 1'b1;
    wait_drain("wrap_drain");
    check_val("wrap_never_full", wrap_full_seen, 32'd0);

    // Flush discards buffered bytes.
    core_ready = 1'b0;
    write_byte(8'h31);
    write_byte(8'h32);
    write_byte(8'h33);
    check_val("pre_flush_empty", fifo_empty, 32'd0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    sb_q.delete();
    check_val("flush_empty", fifo_empty, 32'd1);
    check_val("flush_full",  fifo_full,  32'd0);
    npl        = n_pulses;
    core_ready = 1'b1;
    repeat (8) @(negedge clk);
    check_val("flush_no_pulse", n_pulses - npl, 32'd0);
    write_byte(8'h3C);
    wait_drain("flush_after_write");

    // Reset while the request is held high mid-handshake.
    core_ready = 1'b0;
    pin_data   = 8'h5A;
    pin_wr_req = 1'b1;
    sb_q.push_back(8'h5A);
    wait_ack(1'b1, "rst_mid_ack", c);
    nrst = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
    check_val("rst_mid_ack_low", pin_wr_ack, 32'd0);
    check_val("rst_mid_empty",   fifo_empty, 32'd1);
    npl = n_pulses;
    wait_ack(1'b1, "rst_mid_reack", c);
    check_val("rst_mid_reack_lat", c, 32'd3);
    check_val("rst_mid_one_entry", fifo_empty, 32'd0);
    core_ready = 1'b1;
    pin_wr_req = 1'b0;
    wait_ack(1'b0, "rst_mid_fall", c);
    wait_drain("rst_mid_drain");
    repeat (6) @(negedge clk);
    check_val("rst_mid_single_push", n_pulses - npl, 32'd1);

`ifdef INPUT_HOLDER_LEVEL_EN
    core_ready = 1'b0;
    write_byte(8'h61);
    write_byte(8'h62);
    check_val("level_two", fifo_level, 32'd2);
    core_ready = 1'b1;
    @(negedge clk);
    core_ready = 1'b0;
    check_val("level_one", fifo_level, 32'd1);
    core_ready = 1'b1;
    wait_drain("level_drain");
    @(negedge clk);
    check_val("level_zero", fifo_level, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
